// File: rtl/qa_shim_c0_read_arb.sv
// Two-requester read shim: buffers read requests per port, round-robin merges them toward QLP,
// tags the issuing port in the tag MSB and routes responses back by that bit.
module qa_shim_c0_read_arb #(
  parameter int CCI_DATA_WIDTH   = 512,
  parameter int CCI_RX_HDR_WIDTH = 18,
  parameter int CCI_TX_HDR_WIDTH = 61,
  parameter int CCI_TAG_WIDTH    = 14,
  parameter int FIFO_DEPTH       = 4,
  parameter int MAX_OUTSTANDING  = 64
) (
  input  logic                        clk,
  input  logic                        resetb,
  input  logic [CCI_TX_HDR_WIDTH-1:0] req0_C0TxHdr,
  input  logic                        req0_C0TxRdValid,
  output logic                        req0_C0TxAlmFull,
  output logic [CCI_RX_HDR_WIDTH-1:0] req0_C0RxHdr,
  output logic [CCI_DATA_WIDTH-1:0]   req0_C0RxData,
  output logic                        req0_C0RxRdValid,
  input  logic [CCI_TX_HDR_WIDTH-1:0] req1_C0TxHdr,
  input  logic                        req1_C0TxRdValid,
  output logic                        req1_C0TxAlmFull,
  output logic [CCI_RX_HDR_WIDTH-1:0] req1_C0RxHdr,
  output logic [CCI_DATA_WIDTH-1:0]   req1_C0RxData,
  output logic                        req1_C0RxRdValid,
  output logic [CCI_TX_HDR_WIDTH-1:0] qlp_C0TxHdr,
  output logic                        qlp_C0TxRdValid,
  input  logic                        qlp_C0TxAlmFull,
  input  logic [CCI_RX_HDR_WIDTH-1:0] qlp_C0RxHdr,
  input  logic [CCI_DATA_WIDTH-1:0]   qlp_C0RxData,
  input  logic                        qlp_C0RxRdValid,
  output logic                        err_ovf,
  output logic                        err_unf
);

  localparam int TAG_MSB = CCI_TAG_WIDTH - 1;
  localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int OW      = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [PW-1:0] LAST_C    = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALM_C     = CW'(FIFO_DEPTH - 2);
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);

  logic [CCI_TX_HDR_WIDTH-1:0] req_hdr [2];
  logic                        req_vld [2];

  logic [CCI_TX_HDR_WIDTH-1:0] mem_q    [2][FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr_q [2];
  logic [PW-1:0]               rd_ptr_q [2];
  logic [CW-1:0]               cnt_q    [2];
  logic [CW-1:0]               cnt_d    [2];
  logic [OW-1:0]               out_q    [2];
  logic [OW-1:0]               out_d    [2];
  logic                        alm_q    [2];
  logic                        ptr_q;

  logic                        elig [2];
  logic                        push [2];
  logic                        pop  [2];
  logic                        rsp  [2];
  logic                        gnt_vld;
  logic                        gnt_sel;
  logic [CCI_TX_HDR_WIDTH-1:0] gnt_hdr;
  logic                        rsp_port;
  logic [CCI_RX_HDR_WIDTH-1:0] rsp_hdr;
  logic                        ovf_d;
  logic                        unf_d;

  logic [CCI_TX_HDR_WIDTH-1:0] tx_hdr_q;
  logic                        tx_vld_q;
  logic [CCI_RX_HDR_WIDTH-1:0] rx_hdr_q  [2];
  logic [CCI_DATA_WIDTH-1:0]   rx_data_q [2];
  logic                        rx_vld_q  [2];
  logic                        err_ovf_q;
  logic                        err_unf_q;

  assign req_hdr[0] = req0_C0TxHdr;
  assign req_hdr[1] = req1_C0TxHdr;
  assign req_vld[0] = req0_C0TxRdValid;
  assign req_vld[1] = req1_C0TxRdValid;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
    return (v == LAST_C) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    ovf_d = 1'b0;
    unf_d = 1'b0;
    for (int p = 0; p < 2; p++) begin
      elig[p] = (cnt_q[p] != '0) && (out_q[p] < MAX_OUT_C);
    end
    gnt_vld = !qlp_C0TxAlmFull && (elig[0] || elig[1]);
    // The pointer only matters on a tie; a lone eligible port always wins.
    gnt_sel = (elig[0] && elig[1]) ? ptr_q : elig[1];
    gnt_hdr = mem_q[gnt_sel][rd_ptr_q[gnt_sel]];
    gnt_hdr[TAG_MSB] = gnt_sel;
    rsp_port = qlp_C0RxHdr[TAG_MSB];
    rsp_hdr  = qlp_C0RxHdr;
    rsp_hdr[TAG_MSB] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pop[p]  = gnt_vld && (gnt_sel == 1'(p));
      push[p] = req_vld[p] && ((cnt_q[p] < DEPTH_C) || pop[p]);
      if (req_vld[p] && !push[p]) ovf_d = 1'b1;
      cnt_d[p] = cnt_q[p];
      if (push[p] && !pop[p])      cnt_d[p] = cnt_q[p] + 1'b1;
      else if (!push[p] && pop[p]) cnt_d[p] = cnt_q[p] - 1'b1;
      rsp[p] = qlp_C0RxRdValid && (rsp_port == 1'(p));
      if (rsp[p] && (out_q[p] == '0)) unf_d = 1'b1;
      out_d[p] = out_q[p];
      if (pop[p] && !(rsp[p] && (out_q[p] != '0)))      out_d[p] = out_q[p] + 1'b1;
      else if (!pop[p] && rsp[p] && (out_q[p] != '0))  out_d[p] = out_q[p] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem_q[p][wr_ptr_q[p]] <= req_hdr[p];
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int p = 0; p < 2; p++) begin
        wr_ptr_q[p]  <= '0;
        rd_ptr_q[p]  <= '0;
        cnt_q[p]     <= '0;
        out_q[p]     <= '0;
        alm_q[p]     <= 1'b0;
        rx_hdr_q[p]  <= '0;
        rx_data_q[p] <= '0;
        rx_vld_q[p]  <= 1'b0;
      end
      ptr_q     <= 1'b0;
      tx_hdr_q  <= '0;
      tx_vld_q  <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        cnt_q[p]    <= cnt_d[p];
        out_q[p]    <= out_d[p];
        alm_q[p]    <= (cnt_d[p] >= ALM_C);
        rx_vld_q[p] <= rsp[p];
        if (push[p]) wr_ptr_q[p] <= ptr_inc(wr_ptr_q[p]);
        if (pop[p])  rd_ptr_q[p] <= ptr_inc(rd_ptr_q[p]);
        if (rsp[p]) begin
          rx_hdr_q[p]  <= rsp_hdr;
          rx_data_q[p] <= qlp_C0RxData;
        end
      end
      tx_vld_q <= gnt_vld;
      if (gnt_vld) begin
        tx_hdr_q <= gnt_hdr;
        ptr_q    <= ~gnt_sel;
      end
      err_ovf_q <= err_ovf_q | ovf_d;
      err_unf_q <= err_unf_q | unf_d;
    end
  end

  assign req0_C0TxAlmFull = alm_q[0];
  assign req1_C0TxAlmFull = alm_q[1];
  assign req0_C0RxHdr     = rx_hdr_q[0];
  assign req1_C0RxHdr     = rx_hdr_q[1];
  assign req0_C0RxData    = rx_data_q[0];
  assign req1_C0RxData    = rx_data_q[1];
  assign req0_C0RxRdValid = rx_vld_q[0];
  assign req1_C0RxRdValid = rx_vld_q[1];
  assign qlp_C0TxHdr      = tx_hdr_q;
  assign qlp_C0TxRdValid  = tx_vld_q;
  assign err_ovf          = err_ovf_q;
  assign err_unf          = err_unf_q;

endmodule

// File: tb/tb_qa_shim_c0_read_arb.sv
// Bench for qa_shim_c0_read_arb: vector tables plus directed sequences, with queue scoreboards
// checking every issued request and every routed response.
module tb_qa_shim_c0_read_arb;
  localparam int DW  = 512;
  localparam int RXW = 18;
  localparam int TXW = 61;

  logic           clk = 1'b0;
  logic           resetb = 1'b0;
  logic [TXW-1:0] req0_C0TxHdr, req1_C0TxHdr;
  logic           req0_C0TxRdValid, req1_C0TxRdValid;
  logic           req0_C0TxAlmFull, req1_C0TxAlmFull;
  logic [RXW-1:0] req0_C0RxHdr, req1_C0RxHdr;
  logic [DW-1:0]  req0_C0RxData, req1_C0RxData;
  logic           req0_C0RxRdValid, req1_C0RxRdValid;
  logic [TXW-1:0] qlp_C0TxHdr;
  logic           qlp_C0TxRdValid;
  logic           qlp_C0TxAlmFull;
  logic [RXW-1:0] qlp_C0RxHdr;
  logic [DW-1:0]  qlp_C0RxData;
  logic           qlp_C0RxRdValid;
  logic           err_ovf, err_unf;

  always #5 clk = ~clk;

  qa_shim_c0_read_arb dut (
    .clk(clk), .resetb(resetb),
    .req0_C0TxHdr(req0_C0TxHdr), .req0_C0TxRdValid(req0_C0TxRdValid), .req0_C0TxAlmFull(req0_C0TxAlmFull),
    .req0_C0RxHdr(req0_C0RxHdr), .req0_C0RxData(req0_C0RxData), .req0_C0RxRdValid(req0_C0RxRdValid),
    .req1_C0TxHdr(req1_C0TxHdr), .req1_C0TxRdValid(req1_C0TxRdValid), .req1_C0TxAlmFull(req1_C0TxAlmFull),
    .req1_C0RxHdr(req1_C0RxHdr), .req1_C0RxData(req1_C0RxData), .req1_C0RxRdValid(req1_C0RxRdValid),
    .qlp_C0TxHdr(qlp_C0TxHdr), .qlp_C0TxRdValid(qlp_C0TxRdValid), .qlp_C0TxAlmFull(qlp_C0TxAlmFull),
    .qlp_C0RxHdr(qlp_C0RxHdr), .qlp_C0RxData(qlp_C0RxData), .qlp_C0RxRdValid(qlp_C0RxRdValid),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  typedef struct { logic port; logic [TXW-1:0] hdr; logic [TXW-1:0] exp; } req_vec_t;
  typedef struct { logic [RXW-1:0] hdr; logic [DW-1:0] data; logic port; logic [RXW-1:0] exp; } rsp_vec_t;
  typedef struct { logic port; logic [RXW-1:0] hdr; logic [DW-1:0] data; } rx_exp_t;

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [TXW-1:0] tx_q[$];
  rx_exp_t        rx_q[$];
  req_vec_t       rv[4];
  rsp_vec_t       sv[6];
  logic [TXW-1:0] mon_et;
  rx_exp_t        mon_er;
  int             held;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic port, input logic [TXW-1:0] hdr, input logic [TXW-1:0] exp,
                          input logic expect_issue);
    if (port) begin req1_C0TxHdr = hdr; req1_C0TxRdValid = 1'b1; end
    else      begin req0_C0TxHdr = hdr; req0_C0TxRdValid = 1'b1; end
    if (expect_issue) tx_q.push_back(exp);
    tick();
    req0_C0TxRdValid = 1'b0;
    req1_C0TxRdValid = 1'b0;
  endtask

  task automatic send_rsp(input logic [RXW-1:0] hdr, input logic [DW-1:0] data, input logic port,
                          input logic [RXW-1:0] exp);
    rx_exp_t e;
    qlp_C0RxHdr     = hdr;
    qlp_C0RxData    = data;
    qlp_C0RxRdValid = 1'b1;
    e.port = port; e.hdr = exp; e.data = data;
    rx_q.push_back(e);
    tick();
    qlp_C0RxRdValid = 1'b0;
  endtask

  task automatic reset_dut();
    resetb = 1'b0;
    req0_C0TxRdValid = 1'b0;
    req1_C0TxRdValid = 1'b0;
    qlp_C0RxRdValid  = 1'b0;
    qlp_C0TxAlmFull  = 1'b0;
    tx_q.delete();
    rx_q.delete();
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
  endtask

  // Scoreboard: every issued request and routed response must match the head of its queue.
  always @(negedge clk) begin
    if (resetb) begin
      if (qlp_C0TxRdValid) begin
        if (tx_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_unexpected: got issue %0h, want none", qlp_C0TxHdr);
        end else begin
          mon_et = tx_q.pop_front();
          chk("tx_hdr", DW'(qlp_C0TxHdr), DW'(mon_et));
        end
      end
      if (req0_C0RxRdValid && req1_C0RxRdValid) begin
        n_tests++; n_fail++;
        $display("FAIL rx_both_valid: got 2 valids, want 1");
      end else if (req0_C0RxRdValid || req1_C0RxRdValid) begin
        if (rx_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rx_unexpected: got response on port %0d, want none", req1_C0RxRdValid);
        end else begin
          mon_er = rx_q.pop_front();
          chk("rx_port", DW'(req1_C0RxRdValid), DW'(mon_er.port));
          chk("rx_hdr", DW'(req1_C0RxRdValid ? req1_C0RxHdr : req0_C0RxHdr), DW'(mon_er.hdr));
          chk("rx_data", req1_C0RxRdValid ? req1_C0RxData : req0_C0RxData, mon_er.data);
        end
      end
    end
  end

  initial begin
    req0_C0TxHdr = '0; req1_C0TxHdr = '0;
    req0_C0TxRdValid = 1'b0; req1_C0TxRdValid = 1'b0;
    qlp_C0TxAlmFull = 1'b0; qlp_C0RxHdr = '0; qlp_C0RxData = '0; qlp_C0RxRdValid = 1'b0;

    rv[0] = '{1'b0, 61'h0123_4567_89AB_3FFF, 61'h0123_4567_89AB_1FFF};
    rv[1] = '{1'b1, 61'h1000_0000_0000_0001, 61'h1000_0000_0000_2001};
    rv[2] = '{1'b1, 61'h0FED_CBA9_8765_2222, 61'h0FED_CBA9_8765_2222};
    rv[3] = '{1'b0, 61'h0000_0000_0000_0000, 61'h0000_0000_0000_0000};
    sv[0] = '{18'h3_2005, {16{32'hC0DE_0001}}, 1'b1, 18'h3_0005};
    sv[1] = '{18'h0_0007, {16{32'hC0DE_0002}}, 1'b0, 18'h0_0007};
    sv[2] = '{18'h2_3FFF, {16{32'hC0DE_0003}}, 1'b1, 18'h2_1FFF};
    sv[3] = '{18'h1_1234, {16{32'hC0DE_0004}}, 1'b0, 18'h1_1234};
    sv[4] = '{18'h0_2000, {16{32'hC0DE_0005}}, 1'b1, 18'h0_0000};
    sv[5] = '{18'h3_1FFF, {16{32'hC0DE_0006}}, 1'b0, 18'h3_1FFF};

    // Outputs while held in reset
    #12;
    chk("rst_qlp_vld", DW'(qlp_C0TxRdValid), '0);
    chk("rst_qlp_hdr", DW'(qlp_C0TxHdr), '0);
    chk("rst_alm0", DW'(req0_C0TxAlmFull), '0);
    chk("rst_alm1", DW'(req1_C0TxAlmFull), '0);
    chk("rst_rxv0", DW'(req0_C0RxRdValid), '0);
    chk("rst_rxv1", DW'(req1_C0RxRdValid), '0);
    chk("rst_rxhdr0", DW'(req0_C0RxHdr), '0);
    chk("rst_rxdata1", req1_C0RxData, '0);
    chk("rst_err_ovf", DW'(err_ovf), '0);
    chk("rst_err_unf", DW'(err_unf), '0);
    reset_dut();

    // Simultaneous push on both ports: port 0 issues two cycles later, port 1 the cycle after
    req0_C0TxHdr = 61'h0000_1111_2222_2AAA; req0_C0TxRdValid = 1'b1;
    req1_C0TxHdr = 61'h0000_3333_4444_0055; req1_C0TxRdValid = 1'b1;
    tx_q.push_back(61'h0000_1111_2222_0AAA);
    tx_q.push_back(61'h0000_3333_4444_2055);
    tick();
    req0_C0TxRdValid = 1'b0; req1_C0TxRdValid = 1'b0;
    chk("c1_vld", DW'(qlp_C0TxRdValid), DW'(1'b0));
    tick();
    chk("c2_vld", DW'(qlp_C0TxRdValid), DW'(1'b1));
    chk("c2_hdr", DW'(qlp_C0TxHdr), DW'(61'h0000_1111_2222_0AAA));
    tick();
    chk("c3_vld", DW'(qlp_C0TxRdValid), DW'(1'b1));
    chk("c3_hdr", DW'(qlp_C0TxHdr), DW'(61'h0000_3333_4444_2055));
    tick();
    chk("c4_vld", DW'(qlp_C0TxRdValid), DW'(1'b0));
    chk("c4_hdr_hold", DW'(qlp_C0TxHdr), DW'(61'h0000_3333_4444_2055));

    for (int i = 0; i < 4; i++) send_req(rv[i].port, rv[i].hdr, rv[i].exp, 1'b1);
    repeat (3) tick();
    chk("req_tbl_drain", DW'(tx_q.size()), '0);
    for (int i = 0; i < 6; i++) send_rsp(sv[i].hdr, sv[i].data, sv[i].port, sv[i].exp);
    repeat (2) tick();
    chk("rsp_tbl_drain", DW'(rx_q.size()), '0);
    chk("rsp_tbl_unf", DW'(err_unf), DW'(1'b0));
    chk("rsp_tbl_ovf", DW'(err_ovf), DW'(1'b0));
    send_rsp(18'h0_0042, {16{32'hDEAD_0042}}, 1'b0, 18'h0_0042);
    chk("unf_zero_out", DW'(err_unf), DW'(1'b1));
    tick();
    chk("unf_rsp_routed", DW'(rx_q.size()), '0);

    // Overflow on port 0 while QLP is almost full
    reset_dut();
    qlp_C0TxAlmFull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_req(1'b0, 61'h100 + 61'(i), 61'h100 + 61'(i), i < 4);
      chk("ovf_alm", DW'(req0_C0TxAlmFull), DW'(i >= 1));
      chk("ovf_err", DW'(err_ovf), DW'(i == 4));
    end
    tick();
    chk("ovf_qlp_hold", DW'(qlp_C0TxRdValid), DW'(1'b0));
    qlp_C0TxAlmFull = 1'b0;
    repeat (6) tick();
    chk("ovf_drain", DW'(tx_q.size()), '0);
    chk("ovf_alm_clr", DW'(req0_C0TxAlmFull), DW'(1'b0));
    chk("ovf_sticky", DW'(err_ovf), DW'(1'b1));

    // Outstanding limit on port 1
    reset_dut();
    for (int i = 0; i < 64; i++)
      send_req(1'b1, 61'h1_0000 + 61'(i), (61'h1_0000 + 61'(i)) | 61'h2000, 1'b1);
    send_req(1'b1, 61'h0ABC_0000_0000_0777, '0, 1'b0);
    repeat (3) tick();
    held = 0;
    repeat (8) begin
      tick();
      if (qlp_C0TxRdValid) held++;
    end
    chk("lim_held", DW'(held), '0);
    tx_q.push_back(61'h0ABC_0000_0000_2777);
    send_rsp(18'h0_2005, {16{32'h1234_5678}}, 1'b1, 18'h0_0005);
    chk("lim_rsp_vld1", DW'(req1_C0RxRdValid), DW'(1'b1));
    chk("lim_rsp_hdr1", DW'(req1_C0RxHdr), DW'(18'h0_0005));
    chk("lim_rsp_vld0", DW'(req0_C0RxRdValid), DW'(1'b0));
    tick();
    chk("lim_release", DW'(qlp_C0TxRdValid), DW'(1'b1));
    chk("lim_unf", DW'(err_unf), DW'(1'b0));

    // Grant and response to port 0 in the same cycle keep the outstanding count
    reset_dut();
    for (int i = 0; i < 3; i++) send_req(1'b0, 61'h200 + 61'(i), 61'h200 + 61'(i), 1'b1);
    repeat (3) tick();
    send_req(1'b0, 61'h203, 61'h203, 1'b1);
    send_rsp(18'h0_0011, {16{32'h0000_0011}}, 1'b0, 18'h0_0011);
    for (int i = 0; i < 3; i++)
      send_rsp(18'h0_0020 + 18'(i), {16{32'h0000_0020}}, 1'b0, 18'h0_0020 + 18'(i));
    tick();
    chk("same_cyc_unf", DW'(err_unf), DW'(1'b0));
    send_rsp(18'h0_0030, {16{32'h0000_0030}}, 1'b0, 18'h0_0030);
    chk("same_cyc_unf_end", DW'(err_unf), DW'(1'b1));
    tick();
    chk("same_cyc_drain", DW'(tx_q.size() + rx_q.size()), '0);

    // Reset with requests buffered and reads in flight
    reset_dut();
    send_req(1'b0, 61'h300, 61'h300, 1'b1);
    send_req(1'b0, 61'h301, 61'h301, 1'b1);
    repeat (3) tick();
    qlp_C0TxAlmFull = 1'b1;
    for (int i = 0; i < 3; i++) send_req(1'b0, 61'h310 + 61'(i), '0, 1'b0);
    send_rsp(18'h0_0033, {16{32'h0000_0033}}, 1'b0, 18'h0_0033);
    chk("pre_rst_alm", DW'(req0_C0TxAlmFull), DW'(1'b1));
    chk("pre_rst_rxv", DW'(req0_C0RxRdValid), DW'(1'b1));
    chk("pre_rst_hdr", DW'(qlp_C0TxHdr), DW'(61'h301));
    #1 resetb = 1'b0;
    req0_C0TxHdr = 61'h3FF; req0_C0TxRdValid = 1'b1;
    #1;
    chk("arst_alm", DW'(req0_C0TxAlmFull), '0);
    chk("arst_rxv", DW'(req0_C0RxRdValid), '0);
    chk("arst_rxhdr", DW'(req0_C0RxHdr), '0);
    chk("arst_rxdata", req0_C0RxData, '0);
    chk("arst_qlp_hdr", DW'(qlp_C0TxHdr), '0);
    chk("arst_qlp_vld", DW'(qlp_C0TxRdValid), '0);
    tx_q.delete();
    rx_q.delete();
    qlp_C0TxAlmFull = 1'b0;
    repeat (2) @(posedge clk);
    #1 req0_C0TxRdValid = 1'b0;
    resetb = 1'b1;
    held = 0;
    repeat (8) begin
      tick();
      if (qlp_C0TxRdValid) held++;
    end
    chk("post_rst_issue", DW'(held), '0);
    chk("post_rst_alm", DW'(req0_C0TxAlmFull), '0);
    send_rsp(18'h0_0044, {16{32'h0000_0044}}, 1'b0, 18'h0_0044);
    chk("inflight_unf", DW'(err_unf), DW'(1'b1));
    tick();
    chk("inflight_routed", DW'(rx_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/qa_shim_c0_read_arb.md
QA_SHIM_C0_READ_ARB -- requirements
Module: qa_shim_c0_read_arb

Interface
REQ-001 SHALL have parameter CCI_DATA_WIDTH, default 512, response data width.
REQ-002 SHALL have parameter CCI_RX_HDR_WIDTH, default 18, Rx header width.
REQ-003 SHALL have parameter CCI_TX_HDR_WIDTH, default 61, Tx header width.
REQ-004 SHALL have parameter CCI_TAG_WIDTH, default 14, tag field width; tag occupies header bits [CCI_TAG_WIDTH-1:0] in both Tx and Rx headers.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, per-requester request buffer entries.
REQ-006 SHALL have parameter MAX_OUTSTANDING, default 64, per-requester in-flight read limit.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port resetb, input, 1, asynchronous active-low reset.
REQ-009 SHALL have, for N in {0,1}, port reqN_C0TxHdr, input, CCI_TX_HDR_WIDTH, read request header.
REQ-010 SHALL have reqN_C0TxRdValid, input, 1, read request strobe.
REQ-011 SHALL have reqN_C0TxAlmFull, output, 1, almost-full flow control to requester N.
REQ-012 SHALL have reqN_C0RxHdr, output, CCI_RX_HDR_WIDTH; reqN_C0RxData, output, CCI_DATA_WIDTH; reqN_C0RxRdValid, output, 1: routed read response.
REQ-013 SHALL have qlp_C0TxHdr, output, CCI_TX_HDR_WIDTH; qlp_C0TxRdValid, output, 1; qlp_C0TxAlmFull, input, 1: merged request toward QLP.
REQ-014 SHALL have qlp_C0RxHdr, input, CCI_RX_HDR_WIDTH; qlp_C0RxData, input, CCI_DATA_WIDTH; qlp_C0RxRdValid, input, 1: response from QLP.
REQ-015 SHALL have err_ovf and err_unf, outputs, 1 each, sticky error flags.

Function
REQ-016 Each requester SHALL own a FIFO_DEPTH-entry FIFO; a strobe pushes its header when count<FIFO_DEPTH or a pop occurs that cycle; otherwise request dropped, err_ovf set.
REQ-017 reqN_C0TxAlmFull SHALL be registered, asserted when FIFO N count (after update) >= FIFO_DEPTH-2.
REQ-018 Port N eligible when FIFO N nonempty and outstanding[N] < MAX_OUTSTANDING.
REQ-019 Grant SHALL occur only when qlp_C0TxAlmFull=0 and >=1 port eligible; at most one grant per cycle.
REQ-020 Arbitration SHALL be round-robin: priority pointer selects preferred port; after a grant, pointer points to the non-granted port; sole eligible port wins regardless of pointer.
REQ-021 Granted entry SHALL be popped and appear on qlp_C0TxHdr with qlp_C0TxRdValid=1 the next cycle (registered, latency 1 from grant; min 2 cycles push-to-issue), tag bit [CCI_TAG_WIDTH-1] overwritten with N; other bits unchanged.
REQ-022 qlp_C0TxRdValid SHALL be 0 in cycles without a grant; qlp_C0TxHdr holds last value.
REQ-023 outstanding[N] (width clog2(MAX_OUTSTANDING+1)) SHALL increment on grant to N, decrement on routed response to N, unchanged if both same cycle.
REQ-024 Response with qlp_C0RxRdValid=1 SHALL route to port P=qlp_C0RxHdr[CCI_TAG_WIDTH-1], registered, appearing one cycle later on reqP_C0Rx* with tag bit [CCI_TAG_WIDTH-1] cleared to 0; the other port's RdValid is 0.
REQ-025 Response to port with outstanding=0 SHALL still route, leave counter at 0, and set err_unf.
REQ-026 Requester tags using bit [CCI_TAG_WIDTH-1] are unsupported; that bit is overwritten without error.
REQ-027 err_ovf and err_unf SHALL remain set until reset.

Reset
REQ-028 On resetb=0, asynchronously: FIFOs empty, outstanding counters 0, pointer=port 0, all valid outputs 0, reqN_C0TxAlmFull 0, err flags 0, header/data outputs 0.
REQ-029 Requests presented while resetb=0 SHALL be discarded; in-flight responses arriving after reset deassertion SHALL route per REQ-024 and raise err_unf.

Verification
REQ-030 Both ports push one request each, cycle 0, qlp_C0TxAlmFull=0 -> port 0 issued cycle 2 with tag MSB 0, port 1 cycle 3 with tag MSB 1.
REQ-031 Port 0 pushes 5 back-to-back with qlp_C0TxAlmFull=1 -> AlmFull asserts after 2nd push, 5th push dropped, err_ovf=1, 4 requests issue once AlmFull drops.
REQ-032 Port 1 issues 64 reads, no responses -> 65th held; one response with tag 0x2005 -> routed to req1 with tag 0x0005 next cycle, held request issues.
REQ-033 Grant and response to port 0 same cycle with outstanding=3 -> outstanding stays 3.
REQ-034 Response with tag MSB 0 when outstanding[0]=0 -> delivered to req0, err_unf=1.
REQ-035 Assert resetb=0 with 3 entries buffered and 2 outstanding -> all outputs 0 immediately, nothing issued after release.
